// File: rtl/stage_phv_arbiter.sv
// Round-robin arbiter feeding one match-action stage from NUM_REQ PHV/VLAN sources
// through a single-entry output register, with quiesce, idle status and grant counters.
module stage_phv_arbiter #(
  parameter int PHV_LEN        = 32*64+256,
  parameter int C_VLANID_WIDTH = 12,
  parameter int NUM_REQ        = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                              axis_clk,
  input  logic                              areset,
  input  logic [NUM_REQ*PHV_LEN-1:0]        req_phv,
  input  logic [NUM_REQ-1:0]                req_phv_valid,
  input  logic [NUM_REQ*C_VLANID_WIDTH-1:0] req_vlan,
  input  logic [NUM_REQ-1:0]                req_vlan_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [PHV_LEN-1:0]                phv_out,
  output logic                              phv_out_valid,
  input  logic                              stage_ready_in,
  output logic [C_VLANID_WIDTH-1:0]         vlan_out,
  output logic                              vlan_valid_out,
  input  logic                              vlan_ready_in,
  input  logic                              quiesce,
  output logic                              idle,
  output logic [NUM_REQ*CNT_WIDTH-1:0]      grant_cnt
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic                         r_v;
  logic [PHV_LEN-1:0]           r_phv;
  logic [C_VLANID_WIDTH-1:0]    r_vlan;
  logic [PTR_W-1:0]             r_last;
  logic [NUM_REQ*CNT_WIDTH-1:0] r_cnt;

  logic [NUM_REQ-1:0] w_elig;
  logic [PTR_W-1:0]   w_gnt;
  logic [PTR_W-1:0]   w_cand;
  logic               w_any;
  logic               w_drain;
  logic               w_load;

  assign w_elig = req_phv_valid & req_vlan_valid;

  // Search from the requester after the last grant, wrapping modulo NUM_REQ.
  always_comb begin
    w_any  = 1'b0;
    w_gnt  = '0;
    w_cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = PTR_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_any && w_elig[w_cand]) begin
        w_any = 1'b1;
        w_gnt = w_cand;
      end
    end
  end

  assign w_drain = r_v & stage_ready_in & vlan_ready_in;
  // No grant while reset is held: a consumed PHV would be thrown away with the register.
  assign w_load  = (!r_v | w_drain) & !quiesce & w_any & !areset;

  always_comb begin
    req_ready = '0;
    if (w_load) req_ready[w_gnt] = 1'b1;
  end

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      r_v    <= 1'b0;
      r_phv  <= '0;
      r_vlan <= '0;
      r_last <= PTR_W'(NUM_REQ - 1);
      r_cnt  <= '0;
    end else if (w_load) begin
      r_v    <= 1'b1;
      r_phv  <= req_phv[int'(w_gnt)*PHV_LEN +: PHV_LEN];
      r_vlan <= req_vlan[int'(w_gnt)*C_VLANID_WIDTH +: C_VLANID_WIDTH];
      r_last <= w_gnt;
      r_cnt[int'(w_gnt)*CNT_WIDTH +: CNT_WIDTH] <=
        r_cnt[int'(w_gnt)*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
    end else if (w_drain) begin
      r_v <= 1'b0;
    end
  end

  assign phv_out        = r_phv;
  assign vlan_out       = r_vlan;
  assign phv_out_valid  = r_v;
  assign vlan_valid_out = r_v;
  assign idle           = !r_v & !w_load;
  assign grant_cnt      = r_cnt;

endmodule

// File: tb/tb_stage_phv_arbiter.sv
// Scoreboard bench for stage_phv_arbiter: directed steps push expected PHV/VLAN pairs,
// a negedge monitor pops and compares every entry the stage accepts.
module tb_stage_phv_arbiter;
  localparam int PHV_LEN = 32*64+256;
  localparam int VW      = 12;
  localparam int NR      = 2;
  localparam int CW      = 32;

  typedef struct {
    logic [PHV_LEN-1:0] phv;
    logic [VW-1:0]      vlan;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 areset;
  logic [NR*PHV_LEN-1:0] req_phv;
  logic [NR-1:0]        req_phv_valid;
  logic [NR*VW-1:0]     req_vlan;
  logic [NR-1:0]        req_vlan_valid;
  logic [NR-1:0]        req_ready;
  logic [PHV_LEN-1:0]   phv_out;
  logic                 phv_out_valid;
  logic                 stage_ready_in;
  logic [VW-1:0]        vlan_out;
  logic                 vlan_valid_out;
  logic                 vlan_ready_in;
  logic                 quiesce;
  logic                 idle;
  logic [NR*CW-1:0]     grant_cnt;

  stage_phv_arbiter #(.PHV_LEN(PHV_LEN), .C_VLANID_WIDTH(VW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
    .axis_clk(clk), .areset(areset),
    .req_phv(req_phv), .req_phv_valid(req_phv_valid),
    .req_vlan(req_vlan), .req_vlan_valid(req_vlan_valid), .req_ready(req_ready),
    .phv_out(phv_out), .phv_out_valid(phv_out_valid), .stage_ready_in(stage_ready_in),
    .vlan_out(vlan_out), .vlan_valid_out(vlan_valid_out), .vlan_ready_in(vlan_ready_in),
    .quiesce(quiesce), .idle(idle), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];
  logic [7:0]    tag  [NR];
  logic [VW-1:0] vlan [NR];

  function automatic logic [PHV_LEN-1:0] mk_phv(input logic [7:0] t);
    logic [PHV_LEN-1:0] p;
    p = '0;
    p[7:0]                 = t;
    p[PHV_LEN/2 +: 8]      = t ^ 8'h3C;
    p[PHV_LEN-1 -: 8]      = ~t;
    return p;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive_data();
    req_phv  = {mk_phv(tag[1]), mk_phv(tag[0])};
    req_vlan = {vlan[1], vlan[0]};
  endtask

  // Called at posedge+1: check combinational grant/idle, push the expected pair,
  // cross the clock edge, then give the granted requester fresh data.
  task automatic step(input logic [1:0] exp_rr, input logic exp_idle, input string nm);
    exp_t e;
    #3;
    check({nm, "_req_ready"}, 64'(req_ready), 64'(exp_rr));
    check({nm, "_idle"}, 64'(idle), 64'(exp_idle));
    for (int g = 0; g < NR; g++)
      if (exp_rr[g]) begin
        e.phv  = mk_phv(tag[g]);
        e.vlan = vlan[g];
        sb.push_back(e);
      end
    @(posedge clk); #1;
    for (int g = 0; g < NR; g++)
      if (exp_rr[g]) begin
        tag[g]  = tag[g] + 8'h11;
        vlan[g] = vlan[g] + 12'd1;
      end
    drive_data();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!areset && phv_out_valid && stage_ready_in && vlan_ready_in) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(vlan_out), 64'hFFFF);
      end else begin
        e = sb.pop_front();
        check("mon_phv_lo", phv_out[63:0], e.phv[63:0]);
        check("mon_phv_full", 64'(phv_out == e.phv), 64'd1);
        check("mon_vlan", 64'(vlan_out), 64'(e.vlan));
        check("mon_vlan_valid", 64'(vlan_valid_out), 64'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] hold_vlan;
    logic [7:0]    hold_tag;
    areset = 1'b1; quiesce = 1'b0;
    stage_ready_in = 1'b1; vlan_ready_in = 1'b1;
    req_phv_valid = '0; req_vlan_valid = '0;
    tag[0] = 8'h10; vlan[0] = 12'h100;
    tag[1] = 8'hA5; vlan[1] = 12'h005;
    drive_data();
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;

    check("rst_phv_valid", 64'(phv_out_valid), 64'd0);
    check("rst_vlan_valid", 64'(vlan_valid_out), 64'd0);
    check("rst_phv_out", phv_out[63:0], 64'd0);
    check("rst_vlan_out", 64'(vlan_out), 64'd0);
    check("rst_cnt", grant_cnt, 64'd0);

    // Single source: requester 1 only
    req_phv_valid = 2'b10; req_vlan_valid = 2'b10;
    step(2'b10, 1'b0, "single_grant");
    req_phv_valid = 2'b00; req_vlan_valid = 2'b00;
    check("single_valid_n1", 64'(phv_out_valid), 64'd1);
    check("single_vlan_n1", 64'(vlan_out), 64'h005);
    check("single_phv_n1", 64'(phv_out[7:0]), 64'hA5);
    check("single_cnt1", 64'(grant_cnt[2*CW-1:CW]), 64'd1);
    step(2'b00, 1'b0, "single_drain");
    step(2'b00, 1'b1, "single_idle");

    // Fairness: both valid, last grant was 1
    req_phv_valid = 2'b11; req_vlan_valid = 2'b11;
    for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, "fair");
    req_phv_valid = 2'b00; req_vlan_valid = 2'b00;
    check("fair_cnt0", 64'(grant_cnt[CW-1:0]), 64'd4);
    check("fair_cnt1", 64'(grant_cnt[2*CW-1:CW]), 64'd5);
    step(2'b00, 1'b0, "fair_drain");
    step(2'b00, 1'b1, "fair_idle");

    // Backpressure on requester 0
    req_phv_valid = 2'b01; req_vlan_valid = 2'b01;
    hold_tag = tag[0]; hold_vlan = vlan[0];
    step(2'b01, 1'b0, "bp_load");
    stage_ready_in = 1'b0;
    step(2'b00, 1'b0, "bp_hold_a");
    check("bp_hold_vlan_a", 64'(vlan_out), 64'(hold_vlan));
    step(2'b00, 1'b0, "bp_hold_b");
    stage_ready_in = 1'b1; vlan_ready_in = 1'b0;
    check("bp_hold_phv", 64'(phv_out[7:0]), 64'(hold_tag));
    step(2'b00, 1'b0, "bp_hold_c");
    check("bp_hold_valid", 64'(phv_out_valid), 64'd1);
    vlan_ready_in = 1'b1;
    step(2'b01, 1'b0, "bp_release");
    req_phv_valid = 2'b00; req_vlan_valid = 2'b00;
    step(2'b00, 1'b0, "bp_drain");
    step(2'b00, 1'b1, "bp_idle");

    // Partial valid: requester 0 lacks vlan valid
    req_phv_valid = 2'b11; req_vlan_valid = 2'b10;
    step(2'b10, 1'b0, "part_a");
    step(2'b10, 1'b0, "part_b");
    req_vlan_valid = 2'b11;
    step(2'b01, 1'b0, "part_c");
    req_phv_valid = 2'b00; req_vlan_valid = 2'b00;
    step(2'b00, 1'b0, "part_drain");
    step(2'b00, 1'b1, "part_idle");

    // Quiesce with a pending entry
    req_phv_valid = 2'b11; req_vlan_valid = 2'b11;
    step(2'b10, 1'b0, "q_load");
    quiesce = 1'b1;
    step(2'b00, 1'b0, "q_drain");
    for (int i = 0; i < 5; i++) step(2'b00, 1'b1, "q_idle");
    quiesce = 1'b0;
    step(2'b01, 1'b0, "q_release");

    // Reset while an entry is held by backpressure
    stage_ready_in = 1'b0;
    step(2'b00, 1'b0, "rst_hold");
    areset = 1'b1;
    sb.delete();
    @(posedge clk); #4;
    check("midrst_valid", 64'(phv_out_valid), 64'd0);
    check("midrst_cnt", grant_cnt, 64'd0);
    check("midrst_idle", 64'(idle), 64'd1);
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    step(2'b01, 1'b0, "post_rst_grant");
    stage_ready_in = 1'b1;
    req_phv_valid = 2'b00; req_vlan_valid = 2'b00;
    check("post_rst_cnt0", 64'(grant_cnt[CW-1:0]), 64'd1);
    step(2'b00, 1'b0, "post_rst_drain");
    step(2'b00, 1'b1, "post_rst_idle");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/stage_phv_arbiter.md
Name: stage_phv_arbiter

Overview:
- Round-robin arbiter that shares one match-action stage input between NUM_REQ PHV sources, for example the parser and the recirculation path.
- Each source presents a PHV plus its VLAN ID. The arbiter moves one source's pair per cycle into a single-entry output register that drives the stage's phv_in/vlan_in interfaces.
- A quiesce input stops new grants so the control path can rewrite stage tables while the stage is idle. The block also reports idle status and per-source grant counts.

Parameters:
- PHV_LEN, 32*64+256, width of one PHV.
- C_VLANID_WIDTH, 12, width of the VLAN ID.
- NUM_REQ, 2, number of requesters; legal range 2..4.
- CNT_WIDTH, 32, width of each per-requester grant counter.

Ports:
- axis_clk  in  1  clock.
- areset  in  1  synchronous reset, active-high.
- req_phv  in  NUM_REQ*PHV_LEN  PHV of requester i at bits [i*PHV_LEN +: PHV_LEN].
- req_phv_valid  in  NUM_REQ  PHV valid, one bit per requester.
- req_vlan  in  NUM_REQ*C_VLANID_WIDTH  VLAN ID of requester i.
- req_vlan_valid  in  NUM_REQ  VLAN valid, one bit per requester.
- req_ready  out  NUM_REQ  accept strobe; bit i high means requester i's PHV and VLAN are consumed this cycle.
- phv_out  out  PHV_LEN  to the stage's phv_in.
- phv_out_valid  out  1  to the stage's phv_in_valid.
- stage_ready_in  in  1  from the stage's stage_ready_out.
- vlan_out  out  C_VLANID_WIDTH  to the stage's vlan_in.
- vlan_valid_out  out  1  to the stage's vlan_valid_in.
- vlan_ready_in  in  1  from the stage's vlan_ready_out.
- quiesce  in  1  when high, no new grants are issued.
- idle  out  1  high when the output register is empty and no grant is issued this cycle.
- grant_cnt  out  NUM_REQ*CNT_WIDTH  running grant count per requester.

Behaviour:
- Eligibility: requester i is eligible when req_phv_valid[i] and req_vlan_valid[i] are both high. A requester with only one of the two valid is never granted.
- Output drain: the output register (phv_out, vlan_out, valid bit V) drains when V and stage_ready_in and vlan_ready_in are all high. phv_out_valid and vlan_valid_out both equal V.
- Load enable: load = (!V | drain) & !quiesce & (any eligible). At most one requester is granted per cycle.
- Round-robin:
  - Pointer last is reset to NUM_REQ-1, so requester 0 has first priority after reset.
  - The search starts at (last+1) mod NUM_REQ and wraps modulo NUM_REQ.
  - The first eligible requester g is granted; on load, last <= g.
  - The pointer is unchanged when no load occurs.
- req_ready: req_ready[g] = load, combinationally, in the same cycle; all other bits are 0. req_ready may depend on the valids, but no valid may depend on req_ready.
- Latency and throughput:
  - A grant in cycle N gives phv_out_valid=1 in cycle N+1, carrying requester g's PHV and VLAN.
  - Back-to-back transfers run at 1 per cycle while the stage stays ready.
- Backpressure: if either stage ready is low while V=1, the output holds stable and req_ready stays all-zero.
- Simultaneous drain and load: the register is overwritten with the new pair and V stays 1.
- Drain without load: V goes to 0.
- Quiesce:
  - Quiesce does not stop a pending output from draining; it only blocks new loads.
  - idle = !V & !load. With quiesce high, idle rises in the cycle after the pending entry drains, or immediately if V=0.
  - Deasserting quiesce permits a grant in the same cycle.
- Grant counters:
  - grant_cnt[i] increments by 1 on each load with g=i.
  - The counter wraps from 2^CNT_WIDTH-1 to 0 without saturating.
- Reset values: V=0, phv_out=0, vlan_out=0, phv_out_valid=0, vlan_valid_out=0, req_ready=0, idle=1, grant_cnt=0, last=NUM_REQ-1.
- Reset mid-operation: a held output entry is discarded, not delivered. Requesters keep their valids asserted and are re-arbitrated from requester 0 after reset.
- Prohibited behaviour:
  - The block shall not alter PHV or VLAN contents.
  - No pairing across requesters: a PHV is always delivered with the VLAN from the same requester.

Test Plan:
- Single source: only requester 1 is valid, with PHV containing 0xA5 and VLAN 0x005; both stage readies held high. Expect req_ready=2'b10 in cycle N and phv_out/vlan_out carrying 0xA5/0x005 with valids high in N+1. Expect grant_cnt[1]=1.
- Fairness: both requesters valid continuously and the stage always ready for 8 cycles. Expect grants in the order 0,1,0,1,0,1,0,1, giving grant_cnt = 4 and 4.
- Backpressure: stage_ready_in=0 for 3 cycles with V=1. Expect the output held constant and req_ready=0 throughout. Expect a load in the cycle ready returns, and no lost or duplicated PHV.
- Partial valid: requester 0 has phv valid and vlan invalid, requester 1 has both valid. Expect only requester 1 granted. When requester 0's vlan valid then rises, requester 0 is granted next.
- Quiesce: assert quiesce while V=1 and requesters are valid. Expect one drain, then idle=1 and no grants for 5 cycles. On deassert, expect a grant in the same cycle and idle=0.
- Reset mid-operation: assert areset while V=1 and stage ready is low. Next cycle expect V=0, grant_cnt all 0, and idle=1. Expect the first grant after reset to go to requester 0.
